mem_access_unit: RTL
====================

# mem_access_unit

Memory-access stage controller: the producer side of the MEM→WB valid/ready pipeline handshake. It accepts one load/store/pass-through op at a time from EX/MEM, issues it on the data-SRAM request/response bus, and aligns and extends load data. It then presents the result to the MEM/WB stage register via `ts_valid`/`ns_ready` and holds it until it is taken.

## Interface
Parameters
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; fixed at 32 for byte-lane logic

Ports
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `flush` in 1: synchronous pipeline flush
- `ls_valid` in 1: upstream op valid
- `ts_ready` out 1: unit can accept an op this cycle
- `ls_mem_en` in 1: op accesses memory (0 = pass-through)
- `ls_op` in 4: [1:0] size (0 = byte, 1 = half, 2 = word, 3 = reserved, treated as word); [2] unsigned load; [3] store
- `ls_addr` in ADDR_W: effective address
- `ls_wdata` in DATA_W: store data, low-aligned
- `ls_rw_data` in DATA_W: ALU result for pass-through ops
- `ts_valid` out 1: result valid toward MEM/WB
- `ns_ready` in 1: MEM/WB ready
- `ts_rdata` out DATA_W: load data or passthrough value
- `ts_ale` out 1: address-misaligned exception for the presented op
- `data_req` out 1, `data_wr` out 1, `data_wstrb` out 4, `data_addr` out ADDR_W, `data_wdata` out DATA_W: request channel
- `data_addr_ok` in 1: request accepted
- `data_data_ok` in 1: response (load data or store ack)
- `data_rdata` in DATA_W: load response data

## Operation
- State machine states:
  - IDLE → REQ on accept of a memory op.
  - IDLE → DONE on accept of a pass-through op or a misaligned op.
  - REQ → WAIT on `data_addr_ok`.
  - WAIT → DONE on `data_data_ok`.
  - DONE → IDLE when `ns_ready` and no new accept.
  - DONE → REQ or DONE directly on back-to-back accept.
  - DRAIN → IDLE on `data_data_ok`.
- Accept condition: `ls_valid && ts_ready`, where `ts_ready = (state==IDLE) || (state==DONE && ns_ready)`. The op fields are latched at accept.
- Misalignment check:
  - Half with addr[0] != 0, or word with addr[1:0] != 0, is misaligned.
  - A misaligned op issues no request. It goes to DONE with `ts_ale=1` and `ts_rdata=ls_rw_data`.
- Request channel, driven only in REQ:
  - `data_req=1`; addr, wr, wstrb and wdata are held stable until `data_addr_ok`.
  - `data_addr` has the low 2 bits cleared.
- Store data and strobes:
  - Byte: `wstrb = 4'b0001 << addr[1:0]`, `wdata` = byte replicated ×4.
  - Half: `wstrb = 4'b0011 << addr[1:0]`, `wdata` = half replicated ×2.
  - Word: `wstrb = 4'hF`.
  - Loads drive `wstrb=0`.
- Load data:
  - Select the byte/half at addr[1:0] from `data_rdata`.
  - Sign-extend, or zero-extend when op[2]=1.
  - Capture into `ts_rdata` on `data_data_ok`.
- Store result: `ts_rdata` = latched `ls_rw_data`.
- Flush:
  - In IDLE/DONE/REQ-before-addr_ok → IDLE, nothing is presented.
  - In WAIT, or in REQ with `data_addr_ok` the same cycle → DRAIN. The outstanding response is discarded; `ts_ready=0` in DRAIN.
  - An op offered in a flush cycle is not accepted.
- Only one outstanding request at a time. A `data_data_ok` arriving outside WAIT/DRAIN is ignored.

## Timing
- Reset values (async): state IDLE, `ts_valid=0`, `ts_ale=0`, `ts_rdata=0`, `data_req=0`, `data_wr=0`, `data_wstrb=0`, `data_addr=0`, `data_wdata=0`.
- `ts_valid = (state==DONE)`; all outputs are registered or state-decoded, with no combinational path from `data_*` inputs to `ts_*`.
- Latency counts from the accept cycle N:
  - Pass-through or misaligned: `ts_valid` at N+1.
  - Memory op with `addr_ok` at N+1 and `data_ok` at N+2: `ts_valid` at N+3.
- `data_data_ok` arrives no earlier than the cycle after `data_addr_ok`.
- Throughput:
  - Pass-through ops sustain 1/cycle with `ns_ready=1`.
  - Memory ops sustain at best 1 per 3 cycles.
- Backpressure: when `ns_ready=0` in DONE, `ts_valid`, `ts_rdata` and `ts_ale` hold unchanged.
- `rst` mid-transaction aborts immediately; the memory side is reset in the same domain.

## Test plan
- Pass-through stream: 4 ops with `ls_rw_data` = 1, 2, 3, 4, `ns_ready=1` → `ts_valid` every cycle, `ts_rdata` = 1, 2, 3, 4, `data_req` never asserted.
- Signed byte load: addr 0x1003, `data_rdata`=0x80112233 → `data_addr`=0x1000, `ts_rdata`=0xFFFFFF80. Same load with op[2]=1 → `ts_rdata`=0x00000080.
- Half store: addr 0x2002, `ls_wdata`=0x0000ABCD → `data_wstrb`=4'b1100, `data_wdata`=0xABCDABCD, `data_wr`=1. With `addr_ok` delayed 3 cycles, the request fields stay stable throughout.
- Misaligned word load: addr 0x3001 → no `data_req`, `ts_valid` at N+1 with `ts_ale=1`.
- Flush in WAIT: `flush` the cycle after `addr_ok`, `data_ok` 2 cycles later → `ts_ready=0` until `data_ok`, no `ts_valid`, next op accepted the cycle after `data_ok`.
- Backpressure: load completes with `ns_ready=0` for 5 cycles → `ts_valid` and `ts_rdata` held, `ts_ready=0`. When `ns_ready` rises with `ls_valid=1`, the next op is accepted that same cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage controller: accepts one op from EX/MEM, issues it on the
// data-SRAM request/response bus, aligns/extends load data and hands the result to MEM/WB.
//
// state | meaning
// IDLE  | no op held, ready to accept
// REQ   | request driven on data bus, waiting for data_addr_ok
// WAIT  | request accepted, waiting for data_data_ok
// DONE  | result presented on ts_*, waiting for ns_ready
// DRAIN | flushed with a response still outstanding; discard it

module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ls_valid,
    output logic              ts_ready,
    input  logic              ls_mem_en,
    input  logic [3:0]        ls_op,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [DATA_W-1:0] ls_rw_data,
    output logic              ts_valid,
    input  logic              ns_ready,
    output logic [DATA_W-1:0] ts_rdata,
    output logic              ts_ale,
    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_store;
    logic [DATA_W-1:0] r_rw_data;

    logic              w_misal;
    logic              w_issue;
    logic              w_accept;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;

    // Size code 3 is reserved and behaves as a word.
    assign w_misal  = ((ls_op[1:0] == 2'd1) && ls_addr[0]) ||
                      (ls_op[1] && (ls_addr[1:0] != 2'b00));
    assign w_issue  = ls_mem_en && !w_misal;
    assign ts_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && ns_ready);
    assign w_accept = ls_valid && ts_ready && !flush;
    assign ts_valid = (r_state == S_DONE);

    always_comb begin
        w_wstrb = 4'hF;
        w_wdata = ls_wdata;
        case (ls_op[1:0])
            2'd0: begin
                w_wstrb = 4'b0001 << ls_addr[1:0];
                w_wdata = {4{ls_wdata[7:0]}};
            end
            2'd1: begin
                w_wstrb = 4'b0011 << ls_addr[1:0];
                w_wdata = {2{ls_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = data_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? data_rdata[31:16] : data_rdata[15:0];
        w_load = data_rdata;
        case (r_size)
            2'd0:    w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = w_issue ? S_REQ : S_DONE;
            end
            S_REQ: begin
                if (flush)             w_state_nxt = data_addr_ok ? S_DRAIN : S_IDLE;
                else if (data_addr_ok) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A response landing in the flush cycle itself leaves nothing to drain.
                if (data_data_ok) w_state_nxt = flush ? S_IDLE : S_DONE;
                else if (flush)   w_state_nxt = S_DRAIN;
            end
            S_DONE: begin
                if (w_accept)                w_state_nxt = w_issue ? S_REQ : S_DONE;
                else if (flush || ns_ready)  w_state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (data_data_ok) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_off      <= 2'b00;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_store    <= 1'b0;
            r_rw_data  <= '0;
            ts_rdata   <= '0;
            ts_ale     <= 1'b0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_wstrb <= 4'b0000;
            data_addr  <= '0;
            data_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_off      <= ls_addr[1:0];
                r_size     <= ls_op[1:0];
                r_unsigned <= ls_op[2];
                r_store    <= ls_op[3];
                r_rw_data  <= ls_rw_data;
                if (w_issue) begin
                    data_req   <= 1'b1;
                    data_wr    <= ls_op[3];
                    data_addr  <= {ls_addr[ADDR_W-1:2], 2'b00};
                    data_wstrb <= ls_op[3] ? w_wstrb : 4'b0000;
                    data_wdata <= ls_op[3] ? w_wdata : '0;
                end else begin
                    ts_rdata <= ls_rw_data;
                    ts_ale   <= ls_mem_en && w_misal;
                end
            end else if ((r_state == S_REQ) && (flush || data_addr_ok)) begin
                data_req   <= 1'b0;
                data_wr    <= 1'b0;
                data_addr  <= '0;
                data_wstrb <= 4'b0000;
                data_wdata <= '0;
            end
            if ((r_state == S_WAIT) && data_data_ok && !flush) begin
                ts_rdata <= r_store ? r_rw_data : w_load;
                ts_ale   <= 1'b0;
            end
        end
    end

endmodule
